// File: rtl/pfvf_rtable_lookup.sv
// Runtime-programmable PF/VF routing table: CSR-loaded shadow table with atomic
// commit, and an independent two-stage lookup pipeline per link.
module pfvf_rtable_lookup #(
    parameter int NUM_LINKS    = 1,
    parameter int NUM_ENTRIES  = 8,
    parameter int PF_WIDTH     = 3,
    parameter int VF_WIDTH     = 11,
    parameter int PORT_WIDTH   = 4,
    parameter int DEFAULT_PORT = 0,
    parameter int CNT_WIDTH    = 16,
    localparam int IDX_WIDTH   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_wr_en,
    input  logic [IDX_WIDTH-1:0]            cfg_wr_idx,
    input  logic                            cfg_wr_valid,
    input  logic [PF_WIDTH-1:0]             cfg_wr_pf,
    input  logic [VF_WIDTH-1:0]             cfg_wr_vf,
    input  logic                            cfg_wr_vf_active,
    input  logic [PORT_WIDTH-1:0]           cfg_wr_port,
    input  logic                            cfg_commit,
    output logic                            cfg_commit_done,
    input  logic [NUM_LINKS-1:0]            req_valid,
    output logic [NUM_LINKS-1:0]            req_ready,
    input  logic [NUM_LINKS*PF_WIDTH-1:0]   req_pf,
    input  logic [NUM_LINKS*VF_WIDTH-1:0]   req_vf,
    input  logic [NUM_LINKS-1:0]            req_vf_active,
    output logic [NUM_LINKS-1:0]            rsp_valid,
    input  logic [NUM_LINKS-1:0]            rsp_ready,
    output logic [NUM_LINKS*PORT_WIDTH-1:0] rsp_port,
    output logic [NUM_LINKS-1:0]            rsp_hit,
    output logic [NUM_LINKS*CNT_WIDTH-1:0]  miss_cnt
);

    typedef struct packed {
        logic                  valid;
        logic                  vf_active;
        logic [PF_WIDTH-1:0]   pf;
        logic [VF_WIDTH-1:0]   vf;
        logic [PORT_WIDTH-1:0] port;
    } entry_t;

    entry_t shadow_r [NUM_ENTRIES];
    entry_t shadow_s [NUM_ENTRIES];
    entry_t active_r [NUM_ENTRIES];
    entry_t wr_entry_s;
    logic   commit_done_r;

    // VF number is a don't-care for PF entries (vf_active == 0).
    function automatic logic entry_match(input entry_t ent, input logic [PF_WIDTH-1:0] pf,
                                         input logic [VF_WIDTH-1:0] vf, input logic vf_active);
        return ent.valid && (ent.pf == pf) && (ent.vf_active == vf_active) &&
               (!vf_active || (ent.vf == vf));
    endfunction

    // Shadow next-state with the CSR write merged in, so a same-cycle commit sees it.
    always_comb begin
        wr_entry_s.valid     = cfg_wr_valid;
        wr_entry_s.vf_active = cfg_wr_vf_active;
        wr_entry_s.pf        = cfg_wr_pf;
        wr_entry_s.vf        = cfg_wr_vf;
        wr_entry_s.port      = cfg_wr_port;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (cfg_wr_en && (cfg_wr_idx == IDX_WIDTH'(e))) begin
                shadow_s[e] = wr_entry_s;
            end else begin
                shadow_s[e] = shadow_r[e];
            end
        end
    end

    // Shadow/active table storage and the commit-done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                shadow_r[e] <= '0;
                active_r[e] <= '0;
            end
            commit_done_r <= 1'b0;
        end else begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                shadow_r[e] <= shadow_s[e];
                if (cfg_commit) begin
                    active_r[e] <= shadow_s[e];
                end
            end
            commit_done_r <= cfg_commit;
        end
    end

    assign cfg_commit_done = commit_done_r;

    for (genvar l = 0; l < NUM_LINKS; l++) begin : g_link
        logic [PF_WIDTH-1:0]    key_pf_s;
        logic [VF_WIDTH-1:0]    key_vf_s;
        logic                   key_vfa_s;
        logic [NUM_ENTRIES-1:0] match_s;
        logic [PORT_WIDTH-1:0]  sel_port_s;
        logic                   s1_ready_s;
        logic                   s2_ready_s;
        logic                   s1_valid_r;
        logic [NUM_ENTRIES-1:0] s1_match_r;
        logic [PORT_WIDTH-1:0]  s1_port_r;
        logic                   s2_valid_r;
        logic                   s2_hit_r;
        logic [PORT_WIDTH-1:0]  s2_port_r;
        logic [CNT_WIDTH-1:0]   miss_cnt_r;

        assign key_pf_s  = req_pf[l*PF_WIDTH +: PF_WIDTH];
        assign key_vf_s  = req_vf[l*VF_WIDTH +: VF_WIDTH];
        assign key_vfa_s = req_vf_active[l];

        // Match vector and lowest-index port; the port is captured alongside the
        // vector so a commit cannot alter a lookup already in flight.
        always_comb begin
            match_s    = '0;
            sel_port_s = '0;
            for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
                match_s[e] = entry_match(active_r[e], key_pf_s, key_vf_s, key_vfa_s);
                if (match_s[e]) begin
                    sel_port_s = active_r[e].port;
                end else begin
                    sel_port_s = sel_port_s;
                end
            end
        end

        assign s2_ready_s = !s2_valid_r || rsp_ready[l];
        assign s1_ready_s = !s1_valid_r || s2_ready_s;

        // S1: register match vector for the accepted request.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid_r <= 1'b0;
                s1_match_r <= '0;
                s1_port_r  <= '0;
            end else if (s1_ready_s) begin
                s1_valid_r <= req_valid[l];
                if (req_valid[l]) begin
                    s1_match_r <= match_s;
                    s1_port_r  <= sel_port_s;
                end
            end
        end

        // S2: register resolved port and hit flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_r <= 1'b0;
                s2_hit_r   <= 1'b0;
                s2_port_r  <= '0;
            end else if (s2_ready_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_hit_r  <= |s1_match_r;
                    s2_port_r <= (|s1_match_r) ? s1_port_r : PORT_WIDTH'(DEFAULT_PORT);
                end
            end
        end

        // Saturating miss counter, stepped when a miss response is consumed.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                miss_cnt_r <= '0;
            end else if (s2_valid_r && rsp_ready[l] && !s2_hit_r &&
                         (miss_cnt_r != {CNT_WIDTH{1'b1}})) begin
                miss_cnt_r <= miss_cnt_r + CNT_WIDTH'(1);
            end
        end

        assign req_ready[l]                            = s1_ready_s;
        assign rsp_valid[l]                            = s2_valid_r;
        assign rsp_hit[l]                              = s2_hit_r;
        assign rsp_port[l*PORT_WIDTH +: PORT_WIDTH]    = s2_port_r;
        assign miss_cnt[l*CNT_WIDTH +: CNT_WIDTH]      = miss_cnt_r;
    end

endmodule

// File: tb/tb_pfvf_rtable_lookup.sv
// Directed self-checking bench for pfvf_rtable_lookup (two links, 4-bit counters,
// non-zero default port so miss and reset values are distinguishable).
module tb_pfvf_rtable_lookup;

    localparam int NL  = 2;
    localparam int NE  = 8;
    localparam int PFW = 3;
    localparam int VFW = 11;
    localparam int PW  = 4;
    localparam int DP  = 15;
    localparam int CW  = 4;
    localparam int IW  = 3;

    logic              clk;
    logic              rst_n;
    logic              cfg_wr_en;
    logic [IW-1:0]     cfg_wr_idx;
    logic              cfg_wr_valid;
    logic [PFW-1:0]    cfg_wr_pf;
    logic [VFW-1:0]    cfg_wr_vf;
    logic              cfg_wr_vf_active;
    logic [PW-1:0]     cfg_wr_port;
    logic              cfg_commit;
    logic              cfg_commit_done;
    logic [NL-1:0]     req_valid;
    logic [NL-1:0]     req_ready;
    logic [NL*PFW-1:0] req_pf;
    logic [NL*VFW-1:0] req_vf;
    logic [NL-1:0]     req_vf_active;
    logic [NL-1:0]     rsp_valid;
    logic [NL-1:0]     rsp_ready;
    logic [NL*PW-1:0]  rsp_port;
    logic [NL-1:0]     rsp_hit;
    logic [NL*CW-1:0]  miss_cnt;

    int checks   = 0;
    int failures = 0;

    pfvf_rtable_lookup #(
        .NUM_LINKS(NL), .NUM_ENTRIES(NE), .PF_WIDTH(PFW), .VF_WIDTH(VFW),
        .PORT_WIDTH(PW), .DEFAULT_PORT(DP), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_valid(cfg_wr_valid),
        .cfg_wr_pf(cfg_wr_pf), .cfg_wr_vf(cfg_wr_vf), .cfg_wr_vf_active(cfg_wr_vf_active),
        .cfg_wr_port(cfg_wr_port), .cfg_commit(cfg_commit), .cfg_commit_done(cfg_commit_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_pf(req_pf), .req_vf(req_vf),
        .req_vf_active(req_vf_active), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_port(rsp_port), .rsp_hit(rsp_hit), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int l, input int pf, input int vf, input logic vfa);
        req_pf[l*PFW +: PFW] = PFW'(pf);
        req_vf[l*VFW +: VFW] = VFW'(vf);
        req_vf_active[l]     = vfa;
    endtask

    task automatic cfg_write(input int idx, input logic v, input int pf, input int vf,
                             input logic vfa, input int port, input logic commit);
        cfg_wr_en        = 1'b1;
        cfg_wr_idx       = IW'(idx);
        cfg_wr_valid     = v;
        cfg_wr_pf        = PFW'(pf);
        cfg_wr_vf        = VFW'(vf);
        cfg_wr_vf_active = vfa;
        cfg_wr_port      = PW'(port);
        cfg_commit       = commit;
        tick();
        cfg_wr_en  = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    // Single lookup on link l; lat counts edges from acceptance to rsp_valid.
    task automatic lookup(input int l, input int pf, input int vf, input logic vfa,
                          output logic [PW-1:0] port, output logic hit, output int lat);
        set_key(l, pf, vf, vfa);
        req_valid[l] = 1'b1;
        tick();
        lat = 1;
        req_valid[l] = 1'b0;
        while (!rsp_valid[l] && lat < 10) begin
            tick();
            lat++;
        end
        port = rsp_port[l*PW +: PW];
        hit  = rsp_hit[l];
        tick();
    endtask

    task automatic test_reset();
        logic [PW-1:0] p;
        logic h;
        int lat;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (rsp_port !== 8'h00) begin failures++; $display("FAIL reset_rsp_port got=%h exp=00", rsp_port); end
        checks++; if (rsp_hit !== 2'b00) begin failures++; $display("FAIL reset_rsp_hit got=%b exp=00", rsp_hit); end
        checks++; if (cfg_commit_done !== 1'b0) begin failures++; $display("FAIL reset_commit_done got=%b exp=0", cfg_commit_done); end
        checks++; if (miss_cnt !== 8'h00) begin failures++; $display("FAIL reset_miss_cnt got=%h exp=00", miss_cnt); end
        checks++; if (req_ready !== 2'b11) begin failures++; $display("FAIL reset_req_ready got=%b exp=11", req_ready); end
        rst_n = 1'b1;
        tick();
        lookup(0, 0, 0, 1'b0, p, h, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL first_latency got=%0d exp=2", lat); end
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL empty_hit got=%b exp=0", h); end
        checks++; if (p !== 4'd15) begin failures++; $display("FAIL empty_port got=%0d exp=15", p); end
        checks++; if (miss_cnt[3:0] !== 4'd1) begin failures++; $display("FAIL first_miss_cnt got=%0d exp=1", miss_cnt[3:0]); end
    endtask

    task automatic test_vf_entry();
        logic [PW-1:0] p;
        logic h;
        int lat;
        cfg_write(0, 1'b1, 0, 5, 1'b1, 3, 1'b0);
        do_commit();
        checks++; if (cfg_commit_done !== 1'b1) begin failures++; $display("FAIL commit_done_pulse got=%b exp=1", cfg_commit_done); end
        tick();
        checks++; if (cfg_commit_done !== 1'b0) begin failures++; $display("FAIL commit_done_end got=%b exp=0", cfg_commit_done); end
        cfg_commit = 1'b1;
        tick();
        checks++; if (cfg_commit_done !== 1'b1) begin failures++; $display("FAIL b2b_commit_first got=%b exp=1", cfg_commit_done); end
        tick();
        checks++; if (cfg_commit_done !== 1'b1) begin failures++; $display("FAIL b2b_commit_second got=%b exp=1", cfg_commit_done); end
        cfg_commit = 1'b0;
        tick();
        lookup(0, 0, 5, 1'b1, p, h, lat);
        checks++; if (h !== 1'b1 || p !== 4'd3) begin failures++; $display("FAIL vf_hit got=%b/%0d exp=1/3", h, p); end
        checks++; if (lat != 2) begin failures++; $display("FAIL vf_latency got=%0d exp=2", lat); end
        lookup(0, 0, 6, 1'b1, p, h, lat);
        checks++; if (h !== 1'b0 || p !== 4'd15) begin failures++; $display("FAIL vf_miss got=%b/%0d exp=0/15", h, p); end
        checks++; if (miss_cnt[3:0] !== 4'd2) begin failures++; $display("FAIL vf_miss_cnt got=%0d exp=2", miss_cnt[3:0]); end
    endtask

    task automatic test_shadow();
        logic [PW-1:0] p;
        logic h;
        int lat;
        cfg_write(2, 1'b1, 1, 7, 1'b0, 9, 1'b0);
        lookup(0, 1, 0, 1'b0, p, h, lat);
        checks++; if (h !== 1'b0 || p !== 4'd15) begin failures++; $display("FAIL shadow_uncommitted got=%b/%0d exp=0/15", h, p); end
        do_commit();
        lookup(0, 1, 0, 1'b0, p, h, lat);
        checks++; if (h !== 1'b1 || p !== 4'd9) begin failures++; $display("FAIL shadow_committed got=%b/%0d exp=1/9", h, p); end
        lookup(0, 1, 123, 1'b0, p, h, lat);
        checks++; if (h !== 1'b1 || p !== 4'd9) begin failures++; $display("FAIL pf_vf_ignored got=%b/%0d exp=1/9", h, p); end
    endtask

    task automatic test_priority();
        logic [PW-1:0] p;
        logic h;
        int lat;
        cfg_write(4, 1'b1, 2, 0, 1'b0, 6, 1'b0);
        cfg_write(1, 1'b1, 2, 0, 1'b0, 2, 1'b1);
        lookup(0, 2, 0, 1'b0, p, h, lat);
        checks++; if (h !== 1'b1 || p !== 4'd2) begin failures++; $display("FAIL priority_link0 got=%b/%0d exp=1/2", h, p); end
        lookup(1, 2, 0, 1'b0, p, h, lat);
        checks++; if (h !== 1'b1 || p !== 4'd2) begin failures++; $display("FAIL priority_link1 got=%b/%0d exp=1/2", h, p); end
    endtask

    task automatic test_two_links();
        set_key(0, 1, 0, 1'b0);
        set_key(1, 0, 5, 1'b1);
        req_valid = 2'b11;
        tick();
        req_valid = 2'b00;
        tick();
        checks++; if (rsp_valid !== 2'b11) begin failures++; $display("FAIL two_links_valid got=%b exp=11", rsp_valid); end
        checks++; if (rsp_port !== 8'h39 || rsp_hit !== 2'b11) begin failures++; $display("FAIL two_links_port got=%h/%b exp=39/11", rsp_port, rsp_hit); end
        tick();
    endtask

    task automatic test_back_to_back();
        int kpf [6] = '{0, 1, 2, 3, 0, 1};
        int kvf [6] = '{5, 0, 0, 0, 6, 3};
        logic kvfa [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [PW-1:0] eport [6] = '{4'd3, 4'd9, 4'd2, 4'd15, 4'd15, 4'd9};
        logic ehit [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int sent = 0;
        int rcv = 0;
        logic held_valid = 1'b0;
        logic [PW-1:0] held_port = '0;
        logic held_hit = 1'b0;
        logic acc;
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            rsp_ready[0] = (c >= 5);
            req_valid[0] = (sent < 6);
            if (sent < 6) set_key(0, kpf[sent], kvf[sent], kvfa[sent]);
            #1;
            if (c == 4) begin
                checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL stall_req_ready got=%b exp=0", req_ready[0]); end
            end
            if (rsp_valid[0]) begin
                if (held_valid) begin
                    checks++;
                    if (rsp_port[3:0] !== held_port || rsp_hit[0] !== held_hit) begin
                        failures++; $display("FAIL stall_stable got=%0d/%b exp=%0d/%b", rsp_port[3:0], rsp_hit[0], held_port, held_hit);
                    end
                end
                if (rsp_ready[0]) begin
                    checks++;
                    if (rsp_port[3:0] !== eport[rcv] || rsp_hit[0] !== ehit[rcv]) begin
                        failures++; $display("FAIL stream_rsp%0d got=%0d/%b exp=%0d/%b", rcv, rsp_port[3:0], rsp_hit[0], eport[rcv], ehit[rcv]);
                    end
                    rcv++;
                    held_valid = 1'b0;
                end else begin
                    held_valid = 1'b1;
                    held_port  = rsp_port[3:0];
                    held_hit   = rsp_hit[0];
                end
            end
            acc = req_valid[0] && req_ready[0];
            tick();
            if (acc) sent++;
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        checks++; if (rcv != 6) begin failures++; $display("FAIL stream_count got=%0d exp=6", rcv); end
        tick();
    endtask

    task automatic test_commit_stream();
        int rcv = 0;
        logic [PW-1:0] exp_p;
        cfg_write(2, 1'b1, 1, 0, 1'b0, 5, 1'b0);
        set_key(0, 1, 0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            req_valid[0] = (c < 6);
            cfg_commit   = (c == 2);
            #1;
            if (rsp_valid[0] && rcv < 6) begin
                exp_p = (rcv < 3) ? 4'd9 : 4'd5;
                checks++;
                if (rsp_port[3:0] !== exp_p || rsp_hit[0] !== 1'b1) begin
                    failures++; $display("FAIL commit_stream_rsp%0d got=%0d/%b exp=%0d/1", rcv, rsp_port[3:0], rsp_hit[0], exp_p);
                end
                rcv++;
            end
            tick();
        end
        cfg_commit   = 1'b0;
        req_valid[0] = 1'b0;
        checks++; if (rcv != 6) begin failures++; $display("FAIL commit_stream_count got=%0d exp=6", rcv); end
    endtask

    task automatic test_reset_midstream();
        logic [PW-1:0] p;
        logic h;
        int lat;
        logic seen = 1'b0;
        set_key(0, 0, 5, 1'b1);
        set_key(1, 3, 0, 1'b0);
        req_valid = 2'b11;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 2'b00 || rsp_hit !== 2'b00) begin failures++; $display("FAIL midreset_valid_hit got=%b/%b exp=00/00", rsp_valid, rsp_hit); end
        checks++; if (rsp_port !== 8'h00) begin failures++; $display("FAIL midreset_port got=%h exp=00", rsp_port); end
        checks++; if (miss_cnt !== 8'h00) begin failures++; $display("FAIL midreset_miss_cnt got=%h exp=00", miss_cnt); end
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rsp_valid !== 2'b00) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midreset_dropped got=%b exp=0", seen); end
        lookup(0, 0, 5, 1'b1, p, h, lat);
        checks++; if (h !== 1'b0 || p !== 4'd15) begin failures++; $display("FAIL midreset_table_cleared got=%b/%0d exp=0/15", h, p); end
    endtask

    task automatic test_saturate();
        set_key(1, 7, 0, 1'b0);
        req_valid[1] = 1'b1;
        for (int c = 0; c < 19; c++) tick();
        req_valid[1] = 1'b0;
        repeat (4) tick();
        checks++; if (miss_cnt[7:4] !== 4'd15) begin failures++; $display("FAIL saturate_link1 got=%0d exp=15", miss_cnt[7:4]); end
        checks++; if (miss_cnt[3:0] !== 4'd1) begin failures++; $display("FAIL saturate_link0_indep got=%0d exp=1", miss_cnt[3:0]); end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_valid = 1'b0; cfg_wr_pf = '0;
        cfg_wr_vf = '0; cfg_wr_vf_active = 1'b0; cfg_wr_port = '0; cfg_commit = 1'b0;
        req_valid = '0; req_pf = '0; req_vf = '0; req_vf_active = '0;
        rsp_ready = 2'b11;
        test_reset();
        test_vf_entry();
        test_shadow();
        test_priority();
        test_two_links();
        test_back_to_back();
        test_commit_stream();
        test_reset_midstream();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
